// File: rtl/alu_pipe.sv
// alu_pipe -- single-cycle integer ALU feeding an in-order result queue that
// competes for the common data bus (CDB).
//
// An issued op is evaluated combinationally and written into the queue tail on
// the same edge, so it becomes visible at the queue head one cycle later. The
// head entry is presented on the CDB outputs until the arbiter grants it.
//
// Parameters
//   XLEN   operand / result / address width
//   ROB_W  reorder-buffer tag width
//   DEPTH  result-queue entries (power of two, >= 2)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   valid_i / ready_o   issue handshake from the reservation station
//   op_i                ALU opcode (`ALU_OP_* encodings)
//   vj_i, vk_i, imm_i   operands (vk_i carries the immediate for I-type/LUI/JAL)
//   pc_i, pred_target_i instruction PC and predicted next PC
//   dest_i              destination ROB tag
//   flush_i             mispredict recovery: empties the queue
//   valid_o             queue head requests the CDB
//   rob_id_o, value_o, target_addr_o, branch_outcome_o, mispredict_o
//                       head entry fields (all zero while the queue is empty)
//   cdb_grant_i         CDB grant for the head entry
//
// Optional feature
//   ALU_MISPRED_EN      when defined, each entry records whether the branch
//                       predictor was wrong and drives it on mispredict_o;
//                       otherwise mispredict_o is tied to 0.

`ifndef ALU_OP_DEFS
`define ALU_OP_DEFS
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif
`define AluOpBus     4:0
`define ALU_OP_ADD   5'd0
`define ALU_OP_SUB   5'd1
`define ALU_OP_AND   5'd2
`define ALU_OP_OR    5'd3
`define ALU_OP_XOR   5'd4
`define ALU_OP_SLT   5'd5
`define ALU_OP_SLTU  5'd6
`define ALU_OP_SLL   5'd7
`define ALU_OP_SRL   5'd8
`define ALU_OP_SRA   5'd9
`define ALU_OP_LUI   5'd10
`define ALU_OP_JAL   5'd11
`define ALU_OP_JALR  5'd12
`define ALU_OP_BEQ   5'd13
`define ALU_OP_BNE   5'd14
`define ALU_OP_BLT   5'd15
`define ALU_OP_BGE   5'd16
`define ALU_OP_BLTU  5'd17
`define ALU_OP_BGEU  5'd18
`endif

module alu_pipe #(
  parameter int XLEN  = 32,
  parameter int ROB_W = `ROB_ID_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [`AluOpBus]  op_i,
  input  logic [XLEN-1:0]   vj_i,
  input  logic [XLEN-1:0]   vk_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   pred_target_i,
  input  logic [ROB_W-1:0]  dest_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [ROB_W-1:0]  rob_id_o,
  output logic [XLEN-1:0]   value_o,
  output logic [XLEN-1:0]   target_addr_o,
  output logic              branch_outcome_o,
  output logic              mispredict_o,
  input  logic              cdb_grant_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Branch condition evaluation; signed compares use explicitly signed copies.
  function automatic logic br_taken(input logic [`AluOpBus] op,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] as;
    logic signed [XLEN-1:0] bs;
    as = a;
    bs = b;
    case (op)
      `ALU_OP_BEQ:  br_taken = (a == b);
      `ALU_OP_BNE:  br_taken = (a != b);
      `ALU_OP_BLT:  br_taken = (as < bs);
      `ALU_OP_BGE:  br_taken = (as >= bs);
      `ALU_OP_BLTU: br_taken = (a < b);
      `ALU_OP_BGEU: br_taken = (a >= b);
      default:      br_taken = 1'b0;
    endcase
  endfunction

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             vld_p0;
  logic             pop;

  logic signed [XLEN-1:0] vj_s;
  logic signed [XLEN-1:0] vk_s;
  logic [4:0]             shamt;
  logic [XLEN-1:0]        link_p0;
  logic [XLEN-1:0]        res_p0;
  logic [XLEN-1:0]        tgt_p0;
  logic                   taken_p0;

  assign ready_o = (count != CNT_W'(DEPTH));
  assign valid_o = (count != '0);
  assign vld_p0  = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && cdb_grant_i;

  assign vj_s    = vj_i;
  assign vk_s    = vk_i;
  assign shamt   = vk_i[4:0];
  assign link_p0 = pc_i + XLEN'(4);

  // ---- stage p0: combinational evaluation of the issuing op ----
  always_comb begin
    res_p0   = '0;
    tgt_p0   = '0;
    taken_p0 = 1'b0;
    case (op_i)
      `ALU_OP_ADD:  res_p0 = vj_i + vk_i;
      `ALU_OP_SUB:  res_p0 = vj_i - vk_i;
      `ALU_OP_AND:  res_p0 = vj_i & vk_i;
      `ALU_OP_OR:   res_p0 = vj_i | vk_i;
      `ALU_OP_XOR:  res_p0 = vj_i ^ vk_i;
      `ALU_OP_SLT:  res_p0 = {{(XLEN-1){1'b0}}, (vj_s < vk_s)};
      `ALU_OP_SLTU: res_p0 = {{(XLEN-1){1'b0}}, (vj_i < vk_i)};
      `ALU_OP_SLL:  res_p0 = vj_i << shamt;
      `ALU_OP_SRL:  res_p0 = vj_i >> shamt;
      `ALU_OP_SRA:  res_p0 = vj_s >>> shamt;
      `ALU_OP_LUI:  res_p0 = vk_i;
      `ALU_OP_JAL, `ALU_OP_JALR: begin
        res_p0   = link_p0;
        tgt_p0   = vj_i + vk_i;
        taken_p0 = 1'b1;
      end
      `ALU_OP_BEQ, `ALU_OP_BNE, `ALU_OP_BLT,
      `ALU_OP_BGE, `ALU_OP_BLTU, `ALU_OP_BGEU: begin
        tgt_p0   = pc_i + imm_i;
        taken_p0 = br_taken(op_i, vj_i, vk_i);
      end
      default: ;
    endcase
  end

  // ---- stage p1: result queue (control) ----
  // Flush shares the reset path so it overrides any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (vld_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({vld_p0, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- stage p1: result queue (data, not reset; outputs are gated instead) ----
  logic [ROB_W-1:0] rob_p1   [DEPTH];
  logic [XLEN-1:0]  val_p1   [DEPTH];
  logic [XLEN-1:0]  tgt_p1   [DEPTH];
  logic             taken_p1 [DEPTH];

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      rob_p1[wr_ptr]   <= dest_i;
      val_p1[wr_ptr]   <= res_p0;
      tgt_p1[wr_ptr]   <= tgt_p0;
      taken_p1[wr_ptr] <= taken_p0;
    end
  end

  // Empty-queue gating keeps every output at zero after reset or flush even
  // though the storage itself holds stale contents.
  assign rob_id_o         = valid_o ? rob_p1[rd_ptr]   : '0;
  assign value_o          = valid_o ? val_p1[rd_ptr]   : '0;
  assign target_addr_o    = valid_o ? tgt_p1[rd_ptr]   : '0;
  assign branch_outcome_o = valid_o ? taken_p1[rd_ptr] : 1'b0;

`ifdef ALU_MISPRED_EN
  // A taken op mispredicts if the predictor pointed elsewhere; a not-taken op
  // mispredicts if the predictor did not fall through to pc+4.
  logic mis_p0;
  logic mis_p1 [DEPTH];

  assign mis_p0 = taken_p0 ? (tgt_p0 != pred_target_i)
                           : (pred_target_i != link_p0);

  always_ff @(posedge clk) begin
    if (vld_p0) mis_p1[wr_ptr] <= mis_p0;
  end

  assign mispredict_o = valid_o ? mis_p1[rd_ptr] : 1'b0;
`else
  logic unused_pred;
  assign unused_pred  = ^pred_target_i;
  assign mispredict_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (XLEN=32, ROB_W=4, DEPTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

`ifndef ALU_OP_DEFS
`define ALU_OP_DEFS
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif
`define AluOpBus     4:0
`define ALU_OP_ADD   5'd0
`define ALU_OP_SUB   5'd1
`define ALU_OP_AND   5'd2
`define ALU_OP_OR    5'd3
`define ALU_OP_XOR   5'd4
`define ALU_OP_SLT   5'd5
`define ALU_OP_SLTU  5'd6
`define ALU_OP_SLL   5'd7
`define ALU_OP_SRL   5'd8
`define ALU_OP_SRA   5'd9
`define ALU_OP_LUI   5'd10
`define ALU_OP_JAL   5'd11
`define ALU_OP_JALR  5'd12
`define ALU_OP_BEQ   5'd13
`define ALU_OP_BNE   5'd14
`define ALU_OP_BLT   5'd15
`define ALU_OP_BGE   5'd16
`define ALU_OP_BLTU  5'd17
`define ALU_OP_BGEU  5'd18
`endif

module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  op_i;
  logic [31:0] vj_i, vk_i, imm_i, pc_i, pred_target_i;
  logic [3:0]  dest_i;
  logic        flush_i;
  logic        valid_o;
  logic [3:0]  rob_id_o;
  logic [31:0] value_o, target_addr_o;
  logic        branch_outcome_o;
  logic        mispredict_o;
  logic        cdb_grant_i;

  int checks = 0;
  int errors = 0;
  logic exp_misp;

  alu_pipe #(.XLEN(32), .ROB_W(4), .DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .op_i             (op_i),
    .vj_i             (vj_i),
    .vk_i             (vk_i),
    .imm_i            (imm_i),
    .pc_i             (pc_i),
    .pred_target_i    (pred_target_i),
    .dest_i           (dest_i),
    .flush_i          (flush_i),
    .valid_o          (valid_o),
    .rob_id_o         (rob_id_o),
    .value_o          (value_o),
    .target_addr_o    (target_addr_o),
    .branch_outcome_o (branch_outcome_o),
    .mispredict_o     (mispredict_o),
    .cdb_grant_i      (cdb_grant_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one op for a single cycle.
  task automatic issue(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] pred,
                       input logic [3:0] dest);
    valid_i = 1'b1; op_i = op; vj_i = vj; vk_i = vk; imm_i = imm;
    pc_i = pc; pred_target_i = pred; dest_i = dest;
    tick();
    valid_i = 1'b0;
  endtask

  // Issue with grant=1, check head next cycle, then let it drain.
  task automatic run_vec(input string tag, input logic [4:0] op, input logic [31:0] vj,
                         input logic [31:0] vk, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] e_val, input logic [31:0] e_tgt, input logic e_tk);
    cdb_grant_i = 1'b1;
    issue(op, vj, vk, imm, pc, pc + 32'd4, 4'd5);
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_value"}, value_o, e_val);
    check({tag, "_target"}, target_addr_o, e_tgt);
    check({tag, "_taken"}, 32'(branch_outcome_o), 32'(e_tk));
    tick();
    check({tag, "_drained"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ALU_MISPRED_EN
    exp_misp = 1'b1;
`else
    exp_misp = 1'b0;
`endif
    rst = 1'b1; valid_i = 1'b0; op_i = '0; vj_i = '0; vk_i = '0; imm_i = '0;
    pc_i = '0; pred_target_i = '0; dest_i = '0; flush_i = 1'b0; cdb_grant_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_value", value_o, 32'd0);
    check("rst_rob", 32'(rob_id_o), 32'd0);
    check("rst_target", target_addr_o, 32'd0);
    check("rst_taken", 32'(branch_outcome_o), 32'd0);
    check("rst_misp", 32'(mispredict_o), 32'd0);

    // ADD 5+7 with grant held: latency 1, then popped
    cdb_grant_i = 1'b1;
    issue(`ALU_OP_ADD, 32'd5, 32'd7, 32'd0, 32'h0, 32'h4, 4'd3);
    check("add_valid", 32'(valid_o), 32'd1);
    check("add_value", value_o, 32'd12);
    check("add_rob", 32'(rob_id_o), 32'd3);
    tick();
    check("add_popped", 32'(valid_o), 32'd0);

    // SRA then SLTU held with grant low, then released in order
    cdb_grant_i = 1'b0;
    issue(`ALU_OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 32'h4, 4'd1);
    issue(`ALU_OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h0, 32'h4, 4'd2);
    check("sra_head", value_o, 32'hF800_0000);
    tick();
    check("sra_hold", value_o, 32'hF800_0000);
    check("sra_hold_rob", 32'(rob_id_o), 32'd1);
    cdb_grant_i = 1'b1;
    check("sra_granted", value_o, 32'hF800_0000);
    tick();
    check("sltu_value", value_o, 32'd1);
    check("sltu_rob", 32'(rob_id_o), 32'd2);
    tick();
    check("pair_drained", 32'(valid_o), 32'd0);

    // arithmetic / jump / branch vectors
    run_vec("sub",  `ALU_OP_SUB,  32'd5, 32'd7, 0, 0, 32'hFFFF_FFFE, 0, 1'b0);
    run_vec("and",  `ALU_OP_AND,  32'hF0F0, 32'hFF00, 0, 0, 32'hF000, 0, 1'b0);
    run_vec("or",   `ALU_OP_OR,   32'hF0F0, 32'h0F0F, 0, 0, 32'hFFFF, 0, 1'b0);
    run_vec("xor",  `ALU_OP_XOR,  32'hFFFF, 32'h0F0F, 0, 0, 32'hF0F0, 0, 1'b0);
    run_vec("slt",  `ALU_OP_SLT,  32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 0, 1'b0);
    run_vec("sltu", `ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 0, 1'b0);
    run_vec("sll",  `ALU_OP_SLL,  32'd1, 32'h23, 0, 0, 32'd8, 0, 1'b0);
    run_vec("srl",  `ALU_OP_SRL,  32'h8000_0000, 32'd4, 0, 0, 32'h0800_0000, 0, 1'b0);
    run_vec("lui",  `ALU_OP_LUI,  32'hDEAD, 32'h1234_5000, 0, 0, 32'h1234_5000, 0, 1'b0);
    run_vec("jal",  `ALU_OP_JAL,  32'h1000, 32'h10, 0, 32'h200, 32'h204, 32'h1010, 1'b1);
    run_vec("jalr", `ALU_OP_JALR, 32'h2000, 32'h8, 0, 32'h300, 32'h304, 32'h2008, 1'b1);
    run_vec("unk",  5'd31, 32'd5, 32'd7, 32'h40, 32'h100, 32'd0, 32'd0, 1'b0);
    run_vec("beq",  `ALU_OP_BEQ,  32'd3, 32'd3, 32'h8, 32'h40, 32'd0, 32'h48, 1'b1);
    run_vec("blt",  `ALU_OP_BLT,  32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40, 32'd0, 32'h50, 1'b1);
    run_vec("bge",  `ALU_OP_BGE,  32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40, 32'd0, 32'h50, 1'b0);
    run_vec("bltu", `ALU_OP_BLTU, 32'd1, 32'hFFFF_FFFF, 32'h4, 32'h80, 32'd0, 32'h84, 1'b1);
    run_vec("bgeu", `ALU_OP_BGEU, 32'd1, 32'hFFFF_FFFF, 32'h4, 32'h80, 32'd0, 32'h84, 1'b0);

    // BNE taken, predictor said fall-through
    cdb_grant_i = 1'b0;
    issue(`ALU_OP_BNE, 32'd1, 32'd2, 32'h20, 32'h100, 32'h104, 4'd7);
    check("bne_taken", 32'(branch_outcome_o), 32'd1);
    check("bne_target", target_addr_o, 32'h120);
    check("bne_value", value_o, 32'd0);
    check("bne_misp", 32'(mispredict_o), 32'(exp_misp));
    // taken branch correctly predicted behind it
    issue(`ALU_OP_BEQ, 32'd9, 32'd9, 32'h20, 32'h100, 32'h120, 4'd8);
    cdb_grant_i = 1'b1;
    tick();
    check("beq_pred_ok_misp", 32'(mispredict_o), 32'd0);
    check("beq_pred_ok_rob", 32'(rob_id_o), 32'd8);
    tick();
    check("br_drained", 32'(valid_o), 32'd0);

    // fill to DEPTH with grant low; full blocks a same-cycle issue
    cdb_grant_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(`ALU_OP_ADD, 32'(10 + i), 32'd0, 32'd0, 32'h0, 32'h4, 4'(i));
    end
    check("full_ready", 32'(ready_o), 32'd0);
    check("full_valid", 32'(valid_o), 32'd1);
    check("full_head", value_o, 32'd10);
    cdb_grant_i = 1'b1;
    issue(`ALU_OP_ADD, 32'd99, 32'd0, 32'd0, 32'h0, 32'h4, 4'd9);
    check("after_full_ready", 32'(ready_o), 32'd1);
    check("after_full_head", value_o, 32'd11);
    tick();
    check("drain_12", value_o, 32'd12);
    tick();
    check("drain_13", value_o, 32'd13);
    check("drain_13_rob", 32'(rob_id_o), 32'd3);
    tick();
    check("no_push_when_full", 32'(valid_o), 32'd0);

    // flush with 3 queued and a same-cycle issue
    cdb_grant_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(`ALU_OP_ADD, 32'(20 + i), 32'd0, 32'd0, 32'h0, 32'h4, 4'(i));
    end
    check("pre_flush_valid", 32'(valid_o), 32'd1);
    flush_i = 1'b1;
    issue(`ALU_OP_ADD, 32'd77, 32'd0, 32'd0, 32'h0, 32'h4, 4'd6);
    flush_i = 1'b0;
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_ready", 32'(ready_o), 32'd1);
    check("flush_value", value_o, 32'd0);
    tick();
    check("flush_no_issue", 32'(valid_o), 32'd0);

    // reset mid-operation with 2 queued and grant high
    issue(`ALU_OP_JAL, 32'h1000, 32'h10, 32'd0, 32'h200, 32'h0, 4'd4);
    issue(`ALU_OP_JAL, 32'h3000, 32'h10, 32'd0, 32'h400, 32'h0, 4'd5);
    check("pre_rst_valid", 32'(valid_o), 32'd1);
    cdb_grant_i = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 32'(valid_o), 32'd0);
    check("mrst_ready", 32'(ready_o), 32'd1);
    check("mrst_rob", 32'(rob_id_o), 32'd0);
    check("mrst_value", value_o, 32'd0);
    check("mrst_target", target_addr_o, 32'd0);
    check("mrst_taken", 32'(branch_outcome_o), 32'd0);
    check("mrst_misp", 32'(mispredict_o), 32'd0);
    tick();
    check("mrst_no_request", 32'(valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand/result/address width.
REQ-002 Parameter ROB_W, default `ROB_ID_WIDTH, ROB tag width.
REQ-003 Parameter DEPTH, default 4, result-queue entries; power of two, >=2.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 valid_i  in  1  RS issues an op this cycle.
REQ-007 ready_o  out  1  block can accept an issue this cycle.
REQ-008 op_i  in  `AluOpBus  ALU opcode (`ALU_OP_* encodings).
REQ-009 vj_i, vk_i, imm_i  in  XLEN each  operands; vk_i carries the immediate for I-type/LUI/JAL.
REQ-010 pc_i, pred_target_i  in  XLEN each  instruction PC, predicted next PC.
REQ-011 dest_i  in  ROB_W  destination ROB tag.
REQ-012 flush_i  in  1  pipeline flush (mispredict recovery).
REQ-013 valid_o  out  1  queue head requests CDB.
REQ-014 rob_id_o  out  ROB_W; value_o, target_addr_o  out  XLEN; branch_outcome_o  out  1 (1 = taken); mispredict_o  out  1.
REQ-015 cdb_grant_i  in  1  arbiter grants CDB to queue head.

Function
REQ-016 Issue accepted iff valid_i && ready_o && !flush_i; ready_o = (count != DEPTH), derived from registered count only.
REQ-017 Accepted op computed combinationally, written to queue tail same edge; visible on outputs next cycle (latency 1).
REQ-018 Arithmetic: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL/SRL/SRA (shift = vk_i[4:0], SRA arithmetic), LUI (result = vk_i); all modulo 2^XLEN.
REQ-019 JAL/JALR: result = pc_i+4, target = vj_i+vk_i, taken = 1.
REQ-020 BEQ/BNE/BLT/BGE (signed), BLTU/BGEU (unsigned): taken per compare of vj_i, vk_i; target = pc_i+imm_i; result = 0.
REQ-021 Unknown opcode: result, target, taken all 0; entry still enqueued.
REQ-022 valid_o = (count != 0); outputs driven from head entry; outputs hold stable while valid_o && !cdb_grant_i.
REQ-023 Pop on valid_o && cdb_grant_i; cdb_grant_i ignored when valid_o = 0.
REQ-024 Push and pop same cycle: count unchanged, order preserved (FIFO, in issue order).
REQ-025 Full (count = DEPTH): ready_o = 0 even if a pop occurs this cycle; valid_i ignored.
REQ-026 Pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-027 flush_i: next edge count = 0, pointers = 0, valid_o = 0; same-cycle issue and pop discarded; flush overrides all.

Reset
REQ-028 rst high at edge: count, pointers = 0; valid_o = 0; rob_id_o, value_o, target_addr_o, branch_outcome_o, mispredict_o = 0; ready_o = 1 the cycle after.
REQ-029 Reset mid-operation drops all queued results; no CDB request until a new issue.

Configuration
REQ-030 Macro ALU_MISPRED_EN defined: per entry store mispredict = taken ? (target != pred_target_i) : (pred_target_i != pc_i+4); drive on mispredict_o with head.
REQ-031 ALU_MISPRED_EN undefined: mispredict_o constant 0, pred_target_i unused, no storage for it.

Verification
REQ-032 Issue ADD vj=5 vk=7 dest=3, grant held 1 -> next cycle valid_o=1, value_o=12, rob_id_o=3; following cycle valid_o=0.
REQ-033 Issue SRA vj=0x80000000 vk=4, then SLTU vj=1 vk=0xFFFFFFFF, grant 0 -> head 0xF8000000 held stable; raise grant -> 0xF8000000 then 1 in order.
REQ-034 Issue DEPTH ops with grant 0 -> ready_o=0 after 4th; valid_i held with grant=1 same cycle -> no push; next cycle ready_o=1, count=3.
REQ-035 BNE vj=1 vk=2 pc=0x100 imm=0x20 pred_target=0x104 -> branch_outcome_o=1, target_addr_o=0x120, mispredict_o=1 (0 without ALU_MISPRED_EN).
REQ-036 Queue holding 3 entries, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, issued op not visible.
REQ-037 rst=1 with 2 queued entries and grant=1 -> next cycle all outputs 0, count=0.
